// File: rtl/psum_accumulator_pkg.sv
// Shared constants for the partial-sum accumulator: layer state codes, per-state
// active lane counts, default datapath widths and the FSM state type.
package psum_accumulator_pkg;

    localparam int DEF_MAC_NUM = 120;
    localparam int DEF_DW      = 16;
    localparam int DEF_PW      = 32;
    localparam int DEF_ACC_W   = 40;
    localparam int DEF_FRAC    = 8;
    localparam int TAP_W       = 10;
    localparam int ST_W        = 4;
    localparam int LANE_W      = 8;

    localparam logic [ST_W-1:0] SCONV_1 = 4'd1;
    localparam logic [ST_W-1:0] SCONV_2 = 4'd2;
    localparam logic [ST_W-1:0] SFC_1   = 4'd3;
    localparam logic [ST_W-1:0] SFC_2   = 4'd4;

    localparam logic [LANE_W-1:0] LANES_SCONV_1 = 8'd112;
    localparam logic [LANE_W-1:0] LANES_SCONV_2 = 8'd100;
    localparam logic [LANE_W-1:0] LANES_SFC_1   = 8'd120;
    localparam logic [LANE_W-1:0] LANES_SFC_2   = 8'd84;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ROUND,
        S_HOLD
    } fsm_t;

    function automatic logic [LANE_W-1:0] active_lanes(input logic [ST_W-1:0] st);
        case (st)
            SCONV_1: return LANES_SCONV_1;
            SCONV_2: return LANES_SCONV_2;
            SFC_1:   return LANES_SFC_1;
            SFC_2:   return LANES_SFC_2;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/psum_accumulator_acc_lane.sv
// One accumulator lane: clear/accumulate, bias add, round-half-up, saturate to Q8.8.
// Define RELU_EN to clamp negative saturated results to zero.
module psum_accumulator_acc_lane #(
    parameter int PW    = 32,
    parameter int ACC_W = 40,
    parameter int DW    = 16,
    parameter int FRAC  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_acc,
    input  logic          i_load,
    input  logic          i_active,
    input  logic [PW-1:0] i_prod,
    input  logic [DW-1:0] i_bias,
    output logic [DW-1:0] o_res
);
    // Two guard bits so bias and rounding constant can never wrap the sum.
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC - 1);
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [SW-1:0]    w_sum;
    logic signed [SW-1:0]    w_shr;
    logic [DW-1:0]           w_sat;
    logic [DW-1:0]           w_res;
    logic [DW-1:0]           r_res;

    assign w_prod = {{(ACC_W - PW){i_prod[PW-1]}}, i_prod};
    assign w_sum  = {{2{r_acc[ACC_W-1]}}, r_acc}
                  + {{(SW - DW - FRAC){i_bias[DW-1]}}, i_bias, {FRAC{1'b0}}}
                  + HALF;
    assign w_shr  = w_sum >>> FRAC;

    always_comb begin
        w_sat = w_shr[DW-1:0];
        if (w_shr > MAXV)      w_sat = {1'b0, {(DW - 1){1'b1}}};
        else if (w_shr < MINV) w_sat = {1'b1, {(DW - 1){1'b0}}};
    end

`ifdef RELU_EN
    assign w_res = w_sat[DW-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    // A clear coinciding with a beat loads that beat as the first tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_res <= '0;
        end else begin
            if (i_clr)      r_acc <= i_acc ? w_prod : '0;
            else if (i_acc) r_acc <= r_acc + w_prod;
            if (i_load)     r_res <= i_active ? w_res : '0;
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums MAC lane products over a kernel window, adds bias,
// rounds/saturates per lane and holds the vector for a valid/ready consumer. RELU_EN in lanes.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int MAC_NUM = DEF_MAC_NUM,
    parameter int DW      = DEF_DW,
    parameter int PW      = DEF_PW,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int FRAC    = DEF_FRAC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ST_W-1:0]       cur_state,
    input  logic [TAP_W-1:0]      num_taps,
    input  logic [DW-1:0]         bias,
    input  logic                  mac_valid,
    input  logic [MAC_NUM*PW-1:0] mac_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MAC_NUM*DW-1:0] out_data,
    output logic                  busy,
    output logic                  err_drop
);
    fsm_t               r_state, w_next;
    logic [TAP_W-1:0]   r_taps, r_tap_cnt;
    logic [LANE_W-1:0]  r_act;
    logic [DW-1:0]      r_bias;
    logic               r_err;

    logic [TAP_W-1:0]   w_taps_new, w_taps, w_tap_base;
    logic [LANE_W-1:0]  w_act;
    logic               w_beat, w_last, w_load;

    // A start cycle already runs under the incoming window's parameters.
    assign w_taps_new = (num_taps == '0) ? TAP_W'(1) : num_taps;
    assign w_taps     = start ? w_taps_new : r_taps;
    assign w_act      = start ? active_lanes(cur_state) : r_act;
    assign w_tap_base = start ? '0 : r_tap_cnt;
    assign w_beat     = mac_valid && (start || r_state == S_ACCUM);
    assign w_last     = w_beat && (w_tap_base == w_taps - TAP_W'(1));
    assign w_load     = (r_state == S_ROUND);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = w_last ? S_ROUND : S_ACCUM;
        end else begin
            case (r_state)
                S_ACCUM: if (w_last) w_next = S_ROUND;
                S_ROUND: w_next = S_HOLD;
                S_HOLD:  if (out_ready) w_next = S_IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_taps    <= '0;
            r_tap_cnt <= '0;
            r_act     <= '0;
            r_bias    <= '0;
            r_err     <= 1'b0;
        end else begin
            if (start) begin
                r_taps    <= w_taps_new;
                r_act     <= active_lanes(cur_state);
                r_bias    <= bias;
                r_tap_cnt <= (w_beat && !w_last) ? TAP_W'(1) : '0;
                r_err     <= 1'b0;
            end else begin
                if (w_beat) r_tap_cnt <= w_last ? '0 : r_tap_cnt + TAP_W'(1);
                if (mac_valid && r_state != S_ACCUM) r_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
        psum_accumulator_acc_lane #(
            .PW    (PW),
            .ACC_W (ACC_W),
            .DW    (DW),
            .FRAC  (FRAC)
        ) u_acc_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clr    (start),
            .i_acc    (w_beat && (LANE_W'(i) < w_act)),
            .i_load   (w_load),
            .i_active (LANE_W'(i) < r_act),
            .i_prod   (mac_out[i*PW +: PW]),
            .i_bias   (r_bias),
            .o_res    (out_data[i*DW +: DW])
        );
    end

    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);
    assign err_drop  = r_err;

endmodule
